ram_port_driver: RTL and testbench

//  Initiator for the 4096x12 dual-port RAM: turns a valid/ready request stream into RAM write/read port cycles.

---
 rtl/ram_drv_pkg.sv | 21 ++
 rtl/rsp_fifo.sv | 61 ++++++
 rtl/ram_port_driver.sv | 162 ++++++++++++++++
 tb/tb_ram_port_driver.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_drv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_drv_pkg
// Purpose  : Shared widths and request type for the 4096x12 RAM port driver.
// Revision : 1.0 - initial release
// ============================================================================
package ram_drv_pkg;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 12;
    localparam int BANK_W = 2;
    localparam int OFFS_W = 10;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rsp_fifo
// Purpose  : Synchronous FIFO holding RAM read data until the consumer pops it.
// Revision : 1.0 - initial release
// ============================================================================
module rsp_fifo #(
    parameter  int WIDTH = 12,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_driver.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_driver
// Purpose  : Turns a valid/ready request stream into registered RAM port cycles
//            and returns read data in order through a credit-limited FIFO.
//            Optional RAM_DRV_STATS_EN adds access counters and bank tracking.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_driver
    import ram_drv_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef RAM_DRV_STATS_EN
    ,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt,
    output logic [3:0]        stat_bank_hit
`endif
);

    localparam int                 c_CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RSP_DEPTH);

    req_t                  w_req;
    logic                  w_accept;
    logic                  w_acc_wr;
    logic                  w_acc_rd;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_CNT_W-1:0]    w_fifo_count;
    logic [c_CNT_W-1:0]    w_credits;
    logic [DATA_W-1:0]     w_fifo_data;

    logic                  we_q, we_d;
    logic                  re_q, re_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [ADDR_W-1:0]     raddr_q, raddr_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic [c_CNT_W-1:0]    inflight_q, inflight_d;
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

    assign w_req     = '{write: req_write, addr: req_addr, wdata: req_wdata};
    // A slot is reserved from accept until the consumer pops the data.
    assign w_credits = c_DEPTH - (inflight_q + w_fifo_count);
    assign req_ready = !rst && (w_credits != '0) && !w_fifo_full;
    assign w_accept  = req_valid && req_ready;
    assign w_acc_wr  = w_accept && w_req.write;
    assign w_acc_rd  = w_accept && !w_req.write;
    assign w_push    = rd_pipe_q[RD_LATENCY-1];
    assign w_pop     = rsp_valid && rsp_ready;

    always_comb begin
        we_d    = w_acc_wr;
        re_d    = w_acc_rd;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        din_d   = din_q;
        if (w_acc_wr) begin
            waddr_d = w_req.addr;
            din_d   = w_req.wdata;
        end
        if (w_acc_rd) begin
            raddr_d = w_req.addr;
        end
        // Tag travels alongside the RAM read so the push lines up with valid data.
        rd_pipe_d  = RD_LATENCY'({rd_pipe_q, re_q});
        inflight_d = inflight_q + c_CNT_W'(w_acc_rd) - c_CNT_W'(w_push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            din_q      <= '0;
            inflight_q <= '0;
            rd_pipe_q  <= '0;
        end else begin
            we_q       <= we_d;
            re_q       <= re_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            din_q      <= din_d;
            inflight_q <= inflight_d;
            rd_pipe_q  <= rd_pipe_d;
        end
    end

    rsp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (ram_data_out),
        .pop_i   (w_pop),
        .data_o  (w_fifo_data),
        .count_o (w_fifo_count),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign rsp_valid         = !w_fifo_empty;
    assign rsp_data          = w_fifo_data;
    assign ram_write_address = waddr_q;
    assign ram_read_address  = raddr_q;
    assign ram_data_in       = din_q;
    assign ram_write_enable  = we_q;
    assign ram_read_enable   = re_q;

`ifdef RAM_DRV_STATS_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;
    logic [3:0]  bank_hit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            bank_hit_q <= '0;
        end else begin
            if (we_q && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (re_q && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (w_accept) begin
                bank_hit_q <= 4'b0001 << w_req.addr[OFFS_W +: BANK_W];
            end
        end
    end

    assign stat_wr_cnt   = wr_cnt_q;
    assign stat_rd_cnt   = rd_cnt_q;
    assign stat_bank_hit = bank_hit_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_port_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_driver
// Purpose  : Directed self-checking bench for ram_port_driver with a latency-1
//            RAM model; covers RAM_DRV_STATS_EN when that macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [11:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [11:0] rsp_data;
    logic [11:0] ram_write_address;
    logic [11:0] ram_read_address;
    logic [11:0] ram_data_in;
    logic        ram_write_enable;
    logic        ram_read_enable;
    logic [11:0] ram_data_out = '0;
`ifdef RAM_DRV_STATS_EN
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_rd_cnt;
    logic [3:0]  stat_bank_hit;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] ram_mem [4096];

    always #5 clk = ~clk;

    ram_port_driver #(
        .RD_LATENCY (1),
        .RSP_DEPTH  (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .ram_write_address (ram_write_address),
        .ram_read_address  (ram_read_address),
        .ram_data_in       (ram_data_in),
        .ram_write_enable  (ram_write_enable),
        .ram_read_enable   (ram_read_enable),
        .ram_data_out      (ram_data_out)
`ifdef RAM_DRV_STATS_EN
        ,
        .stat_wr_cnt       (stat_wr_cnt),
        .stat_rd_cnt       (stat_rd_cnt),
        .stat_bank_hit     (stat_bank_hit)
`endif
    );

    // Dual-port RAM with one cycle of read latency.
    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_write_enable) ram_mem[ram_write_address] <= ram_data_in;
        if (ram_read_enable)  ram_data_out <= ram_mem[ram_read_address];
    end

    function automatic logic [11:0] stream_data(input int i);
        return 12'((i * 37 + 5) & 12'hFFF);
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic w, input logic [11:0] a, input logic [11:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout addr %h: req_ready stayed %b, required 1", a, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1;
        req_addr = 12'h123; req_wdata = 12'h456; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks += 4;
            if (ram_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we cyc%0d: got %b want 0", i, ram_write_enable); end
            if (ram_read_enable !== 1'b0)  begin n_fail++; $display("FAIL reset_re cyc%0d: got %b want 0", i, ram_read_enable); end
            if (rsp_valid !== 1'b0)        begin n_fail++; $display("FAIL reset_rsp_valid cyc%0d: got %b want 0", i, rsp_valid); end
            if (req_ready !== 1'b0)        begin n_fail++; $display("FAIL reset_req_ready cyc%0d: got %b want 0", i, req_ready); end
        end
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
        @(negedge clk);
        n_checks += 4;
        if (ram_write_enable !== 1'b0)    begin n_fail++; $display("FAIL post_reset_we: got %b want 0", ram_write_enable); end
        if (ram_write_address !== 12'h0)  begin n_fail++; $display("FAIL post_reset_waddr: got %h want 000", ram_write_address); end
        if (ram_data_in !== 12'h0)        begin n_fail++; $display("FAIL post_reset_din: got %h want 000", ram_data_in); end
        if (ram_read_address !== 12'h0)   begin n_fail++; $display("FAIL post_reset_raddr: got %h want 000", ram_read_address); end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        send(1'b1, 12'hC03, 12'h5A5);
        n_checks += 4;
        if (ram_write_enable !== 1'b1)     begin n_fail++; $display("FAIL wr_we: got %b want 1", ram_write_enable); end
        if (ram_write_address !== 12'hC03) begin n_fail++; $display("FAIL wr_addr: got %h want C03", ram_write_address); end
        if (ram_data_in !== 12'h5A5)       begin n_fail++; $display("FAIL wr_data: got %h want 5A5", ram_data_in); end
        if (ram_read_enable !== 1'b0)      begin n_fail++; $display("FAIL wr_re: got %b want 0", ram_read_enable); end
        send(1'b0, 12'hC03, 12'h000);
        n_checks += 6;
        if (ram_write_enable !== 1'b0)     begin n_fail++; $display("FAIL wr_we_one_cycle: got %b want 0", ram_write_enable); end
        if (ram_read_enable !== 1'b1)      begin n_fail++; $display("FAIL rd_re: got %b want 1", ram_read_enable); end
        if (ram_read_address !== 12'hC03)  begin n_fail++; $display("FAIL rd_addr: got %h want C03", ram_read_address); end
        if (rsp_valid !== 1'b0)            begin n_fail++; $display("FAIL rd_early_valid1: got %b want 0", rsp_valid); end
        if (ram_write_address !== 12'hC03) begin n_fail++; $display("FAIL waddr_hold: got %h want C03", ram_write_address); end
        if (ram_data_in !== 12'h5A5)       begin n_fail++; $display("FAIL din_hold: got %h want 5A5", ram_data_in); end
        @(negedge clk);
        n_checks += 2;
        if (rsp_valid !== 1'b0)       begin n_fail++; $display("FAIL rd_early_valid2: got %b want 0", rsp_valid); end
        if (ram_read_enable !== 1'b0) begin n_fail++; $display("FAIL rd_re_one_cycle: got %b want 0", ram_read_enable); end
        @(negedge clk);
        n_checks += 2;
        if (rsp_valid !== 1'b1)     begin n_fail++; $display("FAIL rd_latency_valid: got %b want 1", rsp_valid); end
        if (rsp_data !== 12'h5A5)   begin n_fail++; $display("FAIL rd_data: got %h want 5A5", rsp_data); end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_popped: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b1;
        send(1'b1, 12'h000, 12'h001);
        send(1'b1, 12'h400, 12'h002);
        send(1'b1, 12'h800, 12'h003);
        send(1'b1, 12'hC00, 12'h004);
        rsp_ready = 1'b0;
        send(1'b0, 12'h000, 12'h000);
        send(1'b0, 12'h400, 12'h000);
        send(1'b0, 12'h800, 12'h000);
        send(1'b0, 12'hC00, 12'h000);
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_credits_out: got %b want 0", req_ready); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall cyc%0d: got %b want 0", i, req_ready); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks += 2;
            if (rsp_valid !== 1'b1)           begin n_fail++; $display("FAIL bp_valid%0d: got %b want 1", i, rsp_valid); end
            if (rsp_data !== 12'(i + 1))      begin n_fail++; $display("FAIL bp_data%0d: got %h want %h", i, rsp_data, 12'(i + 1)); end
            @(negedge clk);
        end
        n_checks += 2;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) send(1'b1, 12'(12'h100 + i), stream_data(i));
        for (int mode = 0; mode < 2; mode++) begin
            int sent = 0, got = 0, cyc = 0, stalls = 0, bad = 0;
            while (got < 100 && cyc < 700) begin
                rsp_ready = (mode == 0) ? 1'b1 : (cyc % 3 != 0);
                if (rsp_valid && rsp_ready) begin
                    if (rsp_data !== stream_data(got) && bad < 5) begin
                        $display("FAIL stream%0d_data idx %0d: got %h want %h", mode, got, rsp_data, stream_data(got));
                    end
                    if (rsp_data !== stream_data(got)) bad++;
                    got++;
                end
                if (sent < 100) begin
                    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'(12'h100 + sent);
                    if (req_ready) sent++; else stalls++;
                end else begin
                    req_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            n_checks += 3;
            if (bad != 0)   begin n_fail++; $display("FAIL stream%0d_order: got %0d bad words want 0", mode, bad); end
            if (got != 100) begin n_fail++; $display("FAIL stream%0d_count: got %0d responses want 100", mode, got); end
            @(negedge clk);
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stream%0d_extra: rsp_valid %b want 0", mode, rsp_valid); end
            if (mode == 0) begin
                n_checks++;
                if (stalls != 0) begin n_fail++; $display("FAIL stream_throughput: got %0d stalls want 0", stalls); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b1;
        send(1'b1, 12'h001, 12'hABC);
        send(1'b0, 12'h100, 12'h000);
        send(1'b0, 12'h101, 12'h000);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid cyc%0d: got %b want 0", i, rsp_valid); end
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready cyc%0d: got %b want 0", i, req_ready); end
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale cyc%0d: got %b want 0", i, rsp_valid); end
        end
        send(1'b0, 12'h001, 12'h000);
        begin
            int n = 0;
            while (!rsp_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            n_checks += 2;
            if (rsp_valid !== 1'b1)   begin n_fail++; $display("FAIL rstmid_resp_timeout: rsp_valid %b want 1", rsp_valid); end
            if (rsp_data !== 12'hABC) begin n_fail++; $display("FAIL rstmid_data: got %h want ABC", rsp_data); end
            @(negedge clk);
        end
    endtask

`ifdef RAM_DRV_STATS_EN
    task automatic test_stats();
        rst = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_checks += 2;
        if (stat_wr_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_clr_wr: got %0d want 0", stat_wr_cnt); end
        if (stat_rd_cnt !== 16'd0) begin n_fail++; $display("FAIL stats_clr_rd: got %0d want 0", stat_rd_cnt); end
        for (int i = 0; i < 5; i++) send(1'b1, 12'(12'h010 + i), 12'(i));
        send(1'b0, 12'h010, 12'h000);
        send(1'b0, 12'h011, 12'h000);
        send(1'b0, 12'h8AB, 12'h000);
        repeat (5) @(negedge clk);
        n_checks += 3;
        if (stat_wr_cnt !== 16'd5)     begin n_fail++; $display("FAIL stats_wr: got %0d want 5", stat_wr_cnt); end
        if (stat_rd_cnt !== 16'd3)     begin n_fail++; $display("FAIL stats_rd: got %0d want 3", stat_rd_cnt); end
        if (stat_bank_hit !== 4'b0100) begin n_fail++; $display("FAIL stats_bank: got %b want 0100", stat_bank_hit); end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
`ifdef RAM_DRV_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
